// File: rtl/rr_mux_sel_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux-select arbiter.
package mux_pkg;

  localparam int unsigned MAX_N_REQ = 16;
  localparam int unsigned BIN_W     = $clog2(MAX_N_REQ);

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_e;

  function automatic logic [BIN_W-1:0] onehot_to_bin(input logic [MAX_N_REQ-1:0] oh);
    logic [BIN_W-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < MAX_N_REQ; i++) begin
      if (oh[i]) b = b | BIN_W'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rr_mux_sel_arbiter_pick.sv
// Combinational round-robin pick: first asserted request scanning from ptr, wrapping at N_REQ.
module rr_pick
  import mux_pkg::*;
#(
  parameter int unsigned N_REQ = 8,
  localparam int unsigned SEL_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] win_idx,
  output logic [N_REQ-1:0] win_oh
);

  int unsigned pos;

  always_comb begin
    found  = 1'b0;
    win_oh = '0;
    pos    = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      // ptr is always < N_REQ, so one conditional subtract wraps correctly
      pos = int'(ptr) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (!found && req[SEL_W'(pos)]) begin
        found               = 1'b1;
        win_oh[SEL_W'(pos)] = 1'b1;
      end
    end
  end

  assign win_idx = SEL_W'(onehot_to_bin(MAX_N_REQ'(win_oh)));

endmodule

// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter driving a registered mux select and one-hot grant, locked until done.
module rr_mux_sel_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned N_REQ = 8,
  localparam int unsigned SEL_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic             busy
);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;

  logic [SEL_W-1:0] ptr_inc;
  logic [SEL_W-1:0] pick_ptr;
  logic             found;
  logic [SEL_W-1:0] win_idx;
  logic [N_REQ-1:0] win_oh;

  assign ptr_inc  = (sel_q == SEL_W'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
  // On done the pick must already see the advanced pointer to allow a bubble-free regrant
  assign pick_ptr = (state_q == LOCKED && done) ? ptr_inc : ptr_q;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req),
    .ptr     (pick_ptr),
    .found   (found),
    .win_idx (win_idx),
    .win_oh  (win_oh)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          sel_d       = win_idx;
          gnt_d       = win_oh;
          gnt_valid_d = 1'b1;
          state_d     = LOCKED;
        end else begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
        end
      end
      LOCKED: begin
        if (done) begin
          ptr_d = ptr_inc;
          if (found) begin
            sel_d = win_idx;
            gnt_d = win_oh;
          end else begin
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign busy      = gnt_valid_q;

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// Scoreboard bench for rr_mux_sel_arbiter with an 8-source and a 5-source instance.
module tb_rr_mux_sel_arbiter;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       gv;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req8 = '0;
  logic       done8 = 1'b0;
  logic [2:0] sel8;
  logic [7:0] gnt8;
  logic       gv8, busy8;
  logic [4:0] req5 = '0;
  logic       done5 = 1'b0;
  logic [2:0] sel5;
  logic [4:0] gnt5;
  logic       gv5, busy5;

  exp_t exp_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rr_mux_sel_arbiter #(.N_REQ(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .done(done8),
    .sel(sel8), .gnt(gnt8), .gnt_valid(gv8), .busy(busy8)
  );

  rr_mux_sel_arbiter #(.N_REQ(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .done(done5),
    .sel(sel5), .gnt(gnt5), .gnt_valid(gv5), .busy(busy5)
  );

  task automatic apply_reset();
    rst_n = 1'b0;
    req8 = '0; done8 = 1'b0;
    req5 = '0; done5 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      req8 = 8'h00; done8 = 1'b0;
      exp_q.push_back('{sel: 3'd0, gnt: 8'h00, gv: 1'b0});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({gv8, busy8, sel8, gnt8} !== {e.gv, e.gv, e.sel, e.gnt}) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: got gv=%b busy=%b sel=%0d gnt=%h exp gv=%b sel=%0d gnt=%h",
                 i, gv8, busy8, sel8, gnt8, e.gv, e.sel, e.gnt);
      end
    end
  endtask

  task automatic test_wrap_81();
    logic [7:0] r [5];
    logic       d [5];
    apply_reset();
    r = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h00};
    d = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
    exp_q.push_back('{sel: 3'd0, gnt: 8'h01, gv: 1'b1});
    exp_q.push_back('{sel: 3'd0, gnt: 8'h01, gv: 1'b1});
    exp_q.push_back('{sel: 3'd7, gnt: 8'h80, gv: 1'b1});
    exp_q.push_back('{sel: 3'd0, gnt: 8'h01, gv: 1'b1});
    exp_q.push_back('{sel: 3'd0, gnt: 8'h00, gv: 1'b0});
    for (int i = 0; i < 5; i++) begin
      req8 = r[i]; done8 = d[i];
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({gv8, busy8, sel8, gnt8} !== {e.gv, e.gv, e.sel, e.gnt}) begin
        errors++;
        $display("FAIL wrap_81 step%0d: got gv=%b busy=%b sel=%0d gnt=%h exp gv=%b sel=%0d gnt=%h",
                 i, gv8, busy8, sel8, gnt8, e.gv, e.sel, e.gnt);
      end
    end
    done8 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int hist [8];
    apply_reset();
    for (int k = 0; k < 8; k++) hist[k] = 0;
    req8 = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      done8 = (i != 0);
      exp_q.push_back('{sel: 3'(i % 8), gnt: 8'(1 << (i % 8)), gv: 1'b1});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      hist[sel8] = hist[sel8] + 1;
      checks++;
      if ({gv8, busy8, sel8, gnt8} !== {e.gv, e.gv, e.sel, e.gnt}) begin
        errors++;
        $display("FAIL b2b grant%0d: got gv=%b sel=%0d gnt=%h exp sel=%0d gnt=%h",
                 i, gv8, sel8, gnt8, e.sel, e.gnt);
      end
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (hist[k] != 2) begin
        errors++;
        $display("FAIL b2b_fairness idx%0d: got %0d grants exp 2", k, hist[k]);
      end
    end
    req8 = 8'h00; done8 = 1'b1;
    @(posedge clk); #1;
    done8 = 1'b0;
  endtask

  task automatic test_hold_locked();
    logic [7:0] r [9];
    logic       d [9];
    apply_reset();
    // grant 3, swap requests while locked, release to 1, then check ptr and idle-done handling
    r = '{8'h08, 8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'hFF, 8'h00, 8'h00};
    d = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1};
    exp_q.push_back('{sel: 3'd3, gnt: 8'h08, gv: 1'b1});
    exp_q.push_back('{sel: 3'd3, gnt: 8'h08, gv: 1'b1});
    exp_q.push_back('{sel: 3'd3, gnt: 8'h08, gv: 1'b1});
    exp_q.push_back('{sel: 3'd3, gnt: 8'h08, gv: 1'b1});
    exp_q.push_back('{sel: 3'd1, gnt: 8'h02, gv: 1'b1});
    exp_q.push_back('{sel: 3'd1, gnt: 8'h00, gv: 1'b0});
    exp_q.push_back('{sel: 3'd2, gnt: 8'h04, gv: 1'b1});
    exp_q.push_back('{sel: 3'd2, gnt: 8'h00, gv: 1'b0});
    exp_q.push_back('{sel: 3'd2, gnt: 8'h00, gv: 1'b0});
    for (int i = 0; i < 9; i++) begin
      req8 = r[i]; done8 = d[i];
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({gv8, busy8, sel8, gnt8} !== {e.gv, e.gv, e.sel, e.gnt}) begin
        errors++;
        $display("FAIL hold_locked step%0d: got gv=%b busy=%b sel=%0d gnt=%h exp gv=%b sel=%0d gnt=%h",
                 i, gv8, busy8, sel8, gnt8, e.gv, e.sel, e.gnt);
      end
    end
    req8 = 8'hFF; done8 = 1'b0;
    exp_q.push_back('{sel: 3'd3, gnt: 8'h08, gv: 1'b1});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if ({gv8, sel8, gnt8} !== {e.gv, e.sel, e.gnt}) begin
      errors++;
      $display("FAIL idle_done_ignored: got gv=%b sel=%0d gnt=%h exp gv=%b sel=%0d gnt=%h",
               gv8, sel8, gnt8, e.gv, e.sel, e.gnt);
    end
    req8 = 8'h00; done8 = 1'b1;
    @(posedge clk); #1;
    done8 = 1'b0;
  endtask

  task automatic test_n5_wrap();
    logic [4:0] r [5];
    logic       d [5];
    apply_reset();
    r = '{5'b00001, 5'b00001, 5'b10001, 5'b10001, 5'b00000};
    d = '{1'b0,     1'b1,     1'b1,     1'b1,     1'b1};
    exp_q.push_back('{sel: 3'd0, gnt: 8'h01, gv: 1'b1});
    exp_q.push_back('{sel: 3'd0, gnt: 8'h01, gv: 1'b1});
    exp_q.push_back('{sel: 3'd4, gnt: 8'h10, gv: 1'b1});
    exp_q.push_back('{sel: 3'd0, gnt: 8'h01, gv: 1'b1});
    exp_q.push_back('{sel: 3'd0, gnt: 8'h00, gv: 1'b0});
    for (int i = 0; i < 5; i++) begin
      req5 = r[i]; done5 = d[i];
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({gv5, busy5, sel5, 3'b000, gnt5} !== {e.gv, e.gv, e.sel, e.gnt}) begin
        errors++;
        $display("FAIL n5_wrap step%0d: got gv=%b busy=%b sel=%0d gnt=%h exp gv=%b sel=%0d gnt=%h",
                 i, gv5, busy5, sel5, gnt5, e.gv, e.sel, e.gnt);
      end
    end
    done5 = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    req8 = 8'h40; done8 = 1'b0;
    exp_q.push_back('{sel: 3'd6, gnt: 8'h40, gv: 1'b1});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if ({gv8, sel8, gnt8} !== {e.gv, e.sel, e.gnt}) begin
      errors++;
      $display("FAIL pre_reset_lock: got gv=%b sel=%0d gnt=%h exp sel=%0d gnt=%h",
               gv8, sel8, gnt8, e.sel, e.gnt);
    end
    #2 rst_n = 1'b0;
    exp_q.push_back('{sel: 3'd0, gnt: 8'h00, gv: 1'b0});
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({gv8, busy8, sel8, gnt8} !== {e.gv, e.gv, e.sel, e.gnt}) begin
      errors++;
      $display("FAIL async_reset_clear: got gv=%b busy=%b sel=%0d gnt=%h exp all zero",
               gv8, busy8, sel8, gnt8);
    end
    #2 rst_n = 1'b1;
    exp_q.push_back('{sel: 3'd6, gnt: 8'h40, gv: 1'b1});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if ({gv8, busy8, sel8, gnt8} !== {e.gv, e.gv, e.sel, e.gnt}) begin
      errors++;
      $display("FAIL post_reset_grant: got gv=%b busy=%b sel=%0d gnt=%h exp sel=%0d gnt=%h",
               gv8, busy8, sel8, gnt8, e.sel, e.gnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wrap_81();
    test_back_to_back();
    test_hold_locked();
    test_n5_wrap();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries exp 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
